// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Contents: arbiter state encoding, bus word width, stall-bus bit positions.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IBUS = 2'b01,
        ARB_DBUS = 2'b10
    } arb_state_e;

    localparam int          REG_W     = 32;
    localparam int          SEL_W     = 4;
    localparam int          STALL_W   = 6;
    localparam int          STALL_IF  = 1;   // IF/ID frozen
    localparam int          STALL_MEM = 4;   // MEM/WB frozen
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic [3:0]  SEL_ALL   = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External memory bus between the arbiter (master) and the memory (slave).
// Signals:
//   bus_cyc   master->slave  transaction active, doubles as strobe
//   bus_we    master->slave  write enable
//   bus_sel   master->slave  byte enables
//   bus_addr  master->slave  address
//   bus_wdata master->slave  write data
//   bus_err   master->slave  one-cycle pulse when a transaction is aborted
//   bus_rdata slave->master  read data, valid with bus_ack
//   bus_ack   slave->master  transaction complete
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic             bus_cyc;
    logic             bus_we;
    logic [SEL_W-1:0] bus_sel;
    logic [REG_W-1:0] bus_addr;
    logic [REG_W-1:0] bus_wdata;
    logic             bus_err;
    logic [REG_W-1:0] bus_rdata;
    logic             bus_ack;

    modport master (
        output bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, bus_err,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM stage.
// Data accesses win over fetches; results are held while the requesting
// stage is frozen and dropped when a flush cancels the transaction.
// Ports:
//   clk, rst (async, active-low)
//   stall[5:0] from ctrl, flush pulse
//   IF side : if_req, if_addr -> if_rdata, stallreq_if
//   MEM side: mem_req, mem_we, mem_sel, mem_addr, mem_wdata -> mem_rdata, stallreq_mem
//   bus     : mem_bus_arbiter_if.master
// Build option: BUS_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog that aborts a
// transaction with no ack, pulses bus_err and completes it with a zero word.
// Without it the arbiter waits for ack indefinitely and bus_err is tied low.
//
// state    | meaning
// ARB_IDLE | no transaction; picks the next requester
// ARB_IBUS | instruction fetch on the bus, waiting for ack
// ARB_DBUS | data load/store on the bus, waiting for ack
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               if_req,
    input  logic [REG_W-1:0]   if_addr,
    output logic [REG_W-1:0]   if_rdata,
    output logic               stallreq_if,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [SEL_W-1:0]   mem_sel,
    input  logic [REG_W-1:0]   mem_addr,
    input  logic [REG_W-1:0]   mem_wdata,
    output logic [REG_W-1:0]   mem_rdata,
    output logic               stallreq_mem,
    mem_bus_arbiter_if.master  bus
);

    arb_state_e       state_q, state_d;
    logic             bus_cyc_q, bus_cyc_d;
    logic             bus_we_q, bus_we_d;
    logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
    logic [REG_W-1:0] bus_addr_q, bus_addr_d;
    logic [REG_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [REG_W-1:0] if_rdata_q, if_rdata_d;
    logic [REG_W-1:0] mem_rdata_q, mem_rdata_d;
    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic             i_cancel_q, i_cancel_d;
    logic             d_cancel_q, d_cancel_d;

    logic             i_want, d_want;
    logic             tmo_hit;
    logic             xfer_end;
    logic [REG_W-1:0] xfer_data;
    logic             stall_unused;

    assign stall_unused = ^{stall[5], stall[3:2], stall[0]};

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;

    assign tmo_hit     = !bus_ack_w() && (tmo_cnt_q == TMO_LAST);
    assign bus.bus_err = bus_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    function automatic logic bus_ack_w();
        return bus.bus_ack;
    endfunction

    // Stall requests are held off during reset so ctrl sees a quiet arbiter.
    assign d_want       = mem_req && !d_done_q && !flush;
    assign i_want       = if_req && !i_done_q && !flush;
    assign stallreq_mem = rst && d_want;
    assign stallreq_if  = rst && i_want;

    assign xfer_end  = bus.bus_ack || tmo_hit;
    assign xfer_data = bus.bus_ack ? bus.bus_rdata : ZERO_WORD;

    always_comb begin
        state_d     = state_q;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        i_done_d    = i_done_q;
        d_done_d    = d_done_q;
        i_cancel_d  = i_cancel_q;
        d_cancel_d  = d_cancel_q;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        bus_err_d   = 1'b0;
`endif

        // Done flags fall once the stage advances; a completion below wins.
        if (!stall[STALL_IF] || flush) begin
            i_done_d = 1'b0;
        end
        if (!stall[STALL_MEM] || flush) begin
            d_done_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (d_want) begin
                    state_d     = ARB_DBUS;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    d_cancel_d  = 1'b0;
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else if (i_want) begin
                    state_d     = ARB_IBUS;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = SEL_ALL;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = ZERO_WORD;
                    i_cancel_d  = 1'b0;
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end

            ARB_IBUS, ARB_DBUS: begin
                if (xfer_end) begin
                    state_d   = ARB_IDLE;
                    bus_cyc_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
                    bus_err_d = tmo_hit;
`endif
                    // A flush arriving with the ack counts as a cancel.
                    if (state_q == ARB_IBUS) begin
                        if (!(i_cancel_q || flush)) begin
                            if_rdata_d = xfer_data;
                            i_done_d   = 1'b1;
                        end
                        i_cancel_d = 1'b0;
                    end else begin
                        if (!(d_cancel_q || flush)) begin
                            if (!bus_we_q || tmo_hit) begin
                                mem_rdata_d = xfer_data;
                            end
                            d_done_d = 1'b1;
                        end
                        d_cancel_d = 1'b0;
                    end
                end else begin
                    if (flush) begin
                        if (state_q == ARB_IBUS) begin
                            i_cancel_d = 1'b1;
                        end else begin
                            d_cancel_d = 1'b1;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d   = ARB_IDLE;
                bus_cyc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= ZERO_WORD;
            bus_wdata_q <= ZERO_WORD;
            if_rdata_q  <= ZERO_WORD;
            mem_rdata_q <= ZERO_WORD;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_cancel_q  <= 1'b0;
            d_cancel_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_cancel_q  <= i_cancel_d;
            d_cancel_q  <= d_cancel_d;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign bus.bus_cyc   = bus_cyc_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign if_rdata      = if_rdata_q;
    assign mem_rdata     = mem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Inputs change 1 ns after the rising
// edge, outputs are sampled 3 ns after it. The DUT is built with
// TIMEOUT_CYCLES=8; with BUS_TIMEOUT_EN defined the watchdog sequence runs too.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        stallreq_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_mem;

    int n_cmp = 0;
    int n_mis = 0;

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .stallreq_if  (stallreq_if),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .stallreq_mem (stallreq_mem),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0;
        if_req = 1'b1; if_addr = '0;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;

        // reset state
        step(); step(); settle();
        chk("rst_cyc", 32'(bus_if.bus_cyc), 32'd0);
        chk("rst_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_err", 32'(bus_if.bus_err), 32'd0);
        chk("rst_sel", 32'(bus_if.bus_sel), 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'd0);
        chk("rst_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_sreq_if", 32'(stallreq_if), 32'd0);
        chk("rst_sreq_mem", 32'(stallreq_mem), 32'd0);
        if_req = 1'b0; mem_req = 1'b0; rst = 1'b1;
        step();

        // 1: load at 0x100, ack on third bus cycle
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h100;
        stall = 6'b010000; settle();
        chk("t1_sreq_c0", 32'(stallreq_mem), 32'd1);
        chk("t1_cyc_c0", 32'(bus_if.bus_cyc), 32'd0);
        step(); settle();
        chk("t1_cyc_c1", 32'(bus_if.bus_cyc), 32'd1);
        chk("t1_addr", bus_if.bus_addr, 32'h100);
        chk("t1_we", 32'(bus_if.bus_we), 32'd0);
        chk("t1_sel", 32'(bus_if.bus_sel), 32'hF);
        chk("t1_sreq_c1", 32'(stallreq_mem), 32'd1);
        step(); settle();
        chk("t1_sreq_c2", 32'(stallreq_mem), 32'd1);
        step(); bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEADBEEF; settle();
        chk("t1_sreq_c3", 32'(stallreq_mem), 32'd1);
        step(); bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0; settle();
        chk("t1_sreq_c4", 32'(stallreq_mem), 32'd0);
        chk("t1_cyc_c4", 32'(bus_if.bus_cyc), 32'd0);
        chk("t1_rdata", mem_rdata, 32'hDEADBEEF);
        step(); settle();
        chk("t1_hold_cyc", 32'(bus_if.bus_cyc), 32'd0);
        chk("t1_hold_rdata", mem_rdata, 32'hDEADBEEF);
        mem_req = 1'b0; stall = '0;
        step();

        // 2: store and fetch requested together; data first
        stall = 6'b010010; mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'h3;
        mem_addr = 32'h200; mem_wdata = 32'hCAFEF00D; if_req = 1'b1; if_addr = 32'h40;
        settle();
        chk("t2_sreq_if_a0", 32'(stallreq_if), 32'd1);
        chk("t2_sreq_mem_a0", 32'(stallreq_mem), 32'd1);
        step(); settle();
        chk("t2_dcyc", 32'(bus_if.bus_cyc), 32'd1);
        chk("t2_dwe", 32'(bus_if.bus_we), 32'd1);
        chk("t2_daddr", bus_if.bus_addr, 32'h200);
        chk("t2_dwdata", bus_if.bus_wdata, 32'hCAFEF00D);
        chk("t2_dsel", 32'(bus_if.bus_sel), 32'h3);
        chk("t2_sreq_if_a1", 32'(stallreq_if), 32'd1);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h11111111;
        step(); bus_if.bus_ack = 1'b0; settle();
        chk("t2_idle_cyc", 32'(bus_if.bus_cyc), 32'd0);
        chk("t2_sreq_mem_a2", 32'(stallreq_mem), 32'd0);
        chk("t2_store_keeps", mem_rdata, 32'hDEADBEEF);
        chk("t2_sreq_if_a2", 32'(stallreq_if), 32'd1);
        step(); settle();
        chk("t2_icyc", 32'(bus_if.bus_cyc), 32'd1);
        chk("t2_iwe", 32'(bus_if.bus_we), 32'd0);
        chk("t2_isel", 32'(bus_if.bus_sel), 32'hF);
        chk("t2_iaddr", bus_if.bus_addr, 32'h40);
        chk("t2_sreq_if_a3", 32'(stallreq_if), 32'd1);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hA5A5A5A5;
        step(); bus_if.bus_ack = 1'b0; mem_req = 1'b0; stall[4] = 1'b0; settle();
        chk("t2_if_rdata", if_rdata, 32'hA5A5A5A5);
        chk("t2_sreq_if_a4", 32'(stallreq_if), 32'd0);
        chk("t2_cyc_a4", 32'(bus_if.bus_cyc), 32'd0);

        // 3: fetched word held while IF/ID is frozen
        if_addr = 32'h44;
        for (int k = 0; k < 5; k++) begin
            step(); settle();
            chk("t3_hold_cyc", 32'(bus_if.bus_cyc), 32'd0);
            chk("t3_hold_rdata", if_rdata, 32'hA5A5A5A5);
        end
        stall[1] = 1'b0; settle();
        chk("t3_sreq_if_done", 32'(stallreq_if), 32'd0);
        step(); settle();
        chk("t3_idle_cyc", 32'(bus_if.bus_cyc), 32'd0);
        chk("t3_sreq_if_new", 32'(stallreq_if), 32'd1);
        stall[1] = 1'b1;
        step(); settle();
        chk("t3_new_cyc", 32'(bus_if.bus_cyc), 32'd1);
        chk("t3_new_addr", bus_if.bus_addr, 32'h44);

        // 4: flush one cycle into the fetch
        step(); flush = 1'b1; settle();
        chk("t4_sreq_if_flush", 32'(stallreq_if), 32'd0);
        chk("t4_cyc_flush", 32'(bus_if.bus_cyc), 32'd1);
        step(); flush = 1'b0; bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678; settle();
        chk("t4_cyc_runs", 32'(bus_if.bus_cyc), 32'd1);
        chk("t4_sreq_if_ack", 32'(stallreq_if), 32'd1);
        step(); bus_if.bus_ack = 1'b0; settle();
        chk("t4_if_rdata_kept", if_rdata, 32'hA5A5A5A5);
        chk("t4_cyc_after", 32'(bus_if.bus_cyc), 32'd0);
        chk("t4_not_done", 32'(stallreq_if), 32'd1);

        // 5: reset in the middle of a transaction
        step(); settle();
        chk("t5_cyc_before", 32'(bus_if.bus_cyc), 32'd1);
        rst = 1'b0; #1;
        chk("t5_cyc_rst", 32'(bus_if.bus_cyc), 32'd0);
        chk("t5_addr_rst", bus_if.bus_addr, 32'd0);
        chk("t5_sel_rst", 32'(bus_if.bus_sel), 32'd0);
        chk("t5_if_rdata_rst", if_rdata, 32'd0);
        chk("t5_mem_rdata_rst", mem_rdata, 32'd0);
        chk("t5_sreq_if_rst", 32'(stallreq_if), 32'd0);
        if_req = 1'b0;
        step(); rst = 1'b1;
        step(); settle();
        chk("t5_idle_cyc", 32'(bus_if.bus_cyc), 32'd0);
        if_req = 1'b1; if_addr = 32'h80; stall = 6'b000010; settle();
        chk("t5_sreq_if", 32'(stallreq_if), 32'd1);
        step(); settle();
        chk("t5_fetch_cyc", 32'(bus_if.bus_cyc), 32'd1);
        chk("t5_fetch_addr", bus_if.bus_addr, 32'h80);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0BADC0DE;
        step(); bus_if.bus_ack = 1'b0; if_req = 1'b0; stall = '0; settle();
        chk("t5_if_rdata", if_rdata, 32'h0BADC0DE);

        // ack and flush together on a load: cancelled, then retried
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300; stall = 6'b010000;
        step(); settle();
        chk("t7_cyc", 32'(bus_if.bus_cyc), 32'd1);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h77777777; flush = 1'b1; #1;
        chk("t7_sreq_flush", 32'(stallreq_mem), 32'd0);
        step(); bus_if.bus_ack = 1'b0; flush = 1'b0; settle();
        chk("t7_rdata_kept", mem_rdata, 32'd0);
        chk("t7_not_done", 32'(stallreq_mem), 32'd1);
        chk("t7_idle", 32'(bus_if.bus_cyc), 32'd0);
        step(); settle();
        chk("t7_retry_cyc", 32'(bus_if.bus_cyc), 32'd1);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h55AA55AA;
        step(); bus_if.bus_ack = 1'b0; settle();
        chk("t7_rdata", mem_rdata, 32'h55AA55AA);
        chk("t7_done", 32'(stallreq_mem), 32'd0);
        mem_req = 1'b0; stall = '0;
        step();

`ifdef BUS_TIMEOUT_EN
        // 6: no ack, watchdog of 8 cycles aborts the load
        mem_req = 1'b1; mem_addr = 32'h400; stall = 6'b010000;
        for (int k = 0; k < 8; k++) begin
            step(); settle();
            chk("t6_cyc_wait", 32'(bus_if.bus_cyc), 32'd1);
            chk("t6_err_wait", 32'(bus_if.bus_err), 32'd0);
        end
        step(); settle();
        chk("t6_cyc_abort", 32'(bus_if.bus_cyc), 32'd0);
        chk("t6_err_pulse", 32'(bus_if.bus_err), 32'd1);
        chk("t6_rdata_zero", mem_rdata, 32'd0);
        chk("t6_done", 32'(stallreq_mem), 32'd0);
        step(); settle();
        chk("t6_err_end", 32'(bus_if.bus_err), 32'd0);
        chk("t6_cyc_end", 32'(bus_if.bus_cyc), 32'd0);
        mem_req = 1'b0; stall = '0;
        step();
`else
        chk("no_tmo_err", 32'(bus_if.bus_err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
